// File: rtl/line_mem_pkg.sv
// Shared constants for the line memory responder: state encoding, default widths, LFSR constants.
package line_mem_pkg;

    localparam int LINE_MEM_ADDR_W = 28;
    localparam int LINE_MEM_LINE_W = 128;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_COOL = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        RESP = ST_RESP,
        COOL = ST_COOL
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1 as a left-shifting Fibonacci register: feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// Line-wide memory request/response bundle between a cache wrapper (master) and the responder (slave).
interface line_mem_responder_if import line_mem_pkg::*; #(
    parameter int ADDR_W = LINE_MEM_ADDR_W,
    parameter int LINE_W = LINE_MEM_LINE_W
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, busy
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, busy
    );
endinterface

// File: rtl/line_mem_responder_lfsr8.sv
// 8-bit Fibonacci LFSR that steps once per enable; only built when LINE_MEM_JITTER_EN is defined.
module lfsr8 import line_mem_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] seed,
    output logic [7:0] state
);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= seed;
        end else if (enable) begin
            state <= lfsr_step(state);
        end
    end
endmodule

// File: rtl/line_mem_responder.sv
// Line-addressed memory slave answering one request at a time after LATENCY cycles.
// Optional LINE_MEM_JITTER_EN adds 0..3 pseudo-random wait cycles per request.
//
// state | meaning
// IDLE  | waiting for mem_read / mem_write
// WAIT  | latency countdown on latched request
// RESP  | mem_ready pulse; array write / read data registered on entry
// COOL  | one cycle ignoring the initiator's trailing request
module line_mem_responder import line_mem_pkg::*; #(
    parameter int ADDR_W     = LINE_MEM_ADDR_W,
    parameter int LINE_W     = LINE_MEM_LINE_W,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 proc_reset,
    line_mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = 5;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    op_write_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [LINE_W-1:0]       wdata_q;
    logic [LINE_W-1:0]       rdata_q;
    logic [LINE_W-1:0]       mem [DEPTH];

    logic                    accept;
    logic                    enter_resp;
    logic [1:0]              extra;
    logic [CNT_W-1:0]        load_val;
    logic                    direct;
    logic                    commit_write;
    logic [DEPTH_LOG2-1:0]   commit_idx;
    logic [LINE_W-1:0]       commit_data;
    logic                    unused_addr_hi;

    assign accept = (state_q == IDLE) && (bus.mem_read || bus.mem_write);

`ifdef LINE_MEM_JITTER_EN
    logic [7:0] lfsr_state;
    logic       unused_lfsr_hi;

    lfsr8 u_lfsr8 (
        .clk    (clk),
        .rst    (proc_reset),
        .enable (accept),
        .seed   (LFSR_SEED),
        .state  (lfsr_state)
    );

    assign extra          = lfsr_state[1:0];
    assign unused_lfsr_hi = ^lfsr_state[7:2];
`else
    assign extra = 2'd0;
`endif

    // cnt holds the number of WAIT cycles still to spend; zero means respond straight from IDLE
    assign load_val = CNT_W'(LATENCY - 1) + CNT_W'(extra);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (load_val == '0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = load_val;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // On the single-cycle path the request has not been latched yet, so take it from the bus
    assign direct       = (state_q == IDLE);
    assign commit_write = direct ? bus.mem_write                     : op_write_q;
    assign commit_idx   = direct ? bus.mem_addr[DEPTH_LOG2-1:0]      : idx_q;
    assign commit_data  = direct ? bus.mem_wdata                     : wdata_q;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_write_q <= bus.mem_write;
                idx_q      <= bus.mem_addr[DEPTH_LOG2-1:0];
                wdata_q    <= bus.mem_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            rdata_q <= '0;
        end else if (enter_resp && !commit_write) begin
            rdata_q <= mem[commit_idx];
        end
    end

    // Contents survive reset; an aborted write never reaches the array
    always_ff @(posedge clk) begin
        if (!proc_reset && enter_resp && commit_write) begin
            mem[commit_idx] <= commit_data;
        end
    end

    assign bus.mem_rdata  = rdata_q;
    assign bus.mem_ready  = (state_q == RESP);
    assign bus.busy       = (state_q != IDLE);
    assign unused_addr_hi = ^bus.mem_addr[ADDR_W-1:DEPTH_LOG2];

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: age-based reference model plus directed scenarios.
module tb_line_mem_responder;

    localparam int LAT = 4;
    localparam logic [127:0] D1 = 128'hDEADBEEF_00000001_CAFEF00D_12345678;

    logic clk = 1'b0;
    logic proc_reset;

    always #5 clk = ~clk;

    line_mem_responder_if #(.ADDR_W(28), .LINE_W(128)) bus();

    line_mem_responder #(
        .ADDR_W     (28),
        .LINE_W     (128),
        .DEPTH_LOG2 (8),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference model: a request accepted at edge 0 responds after edge rlat = LAT-1+extra,
    // stays busy through edge rlat+1 and is idle again from edge rlat+2.
    logic [127:0] m_mem [256];
    bit           m_valid [256];
    int           m_age = -1;
    int           m_rlat = 0;
    bit           m_wr = 0;
    logic [7:0]   m_idx = '0;
    logic [127:0] m_wd = '0;
    logic [127:0] m_rdata = '0;
    bit           m_rdata_known = 0;
    int           m_last_extra = 0;
    logic [7:0]   m_lfsr = 8'hA5;
    bit           model_on = 0;

    task automatic m_commit();
        if (m_wr) begin
            m_mem[m_idx]   = m_wd;
            m_valid[m_idx] = 1'b1;
        end else begin
            m_rdata       = m_mem[m_idx];
            m_rdata_known = m_valid[m_idx];
        end
    endtask

    always @(posedge clk) begin
        if (proc_reset === 1'b1) begin
            model_on      = 1;
            m_age         = -1;
            m_rdata       = '0;
            m_rdata_known = 1;
            m_lfsr        = 8'hA5;
        end else if (model_on) begin
            if (m_age < 0) begin
                if (bus.mem_read || bus.mem_write) begin
                    m_wr  = bus.mem_write;
                    m_idx = bus.mem_addr[7:0];
                    m_wd  = bus.mem_wdata;
`ifdef LINE_MEM_JITTER_EN
                    m_last_extra = int'(m_lfsr[1:0]);
                    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`else
                    m_last_extra = 0;
`endif
                    m_rlat = LAT - 1 + m_last_extra;
                    m_age  = 0;
                    if (m_rlat == 0) m_commit();
                end
            end else begin
                m_age++;
                if (m_age == m_rlat) m_commit();
                if (m_age > m_rlat + 1) m_age = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on && proc_reset !== 1'b1) begin
            check("ready", 128'(bus.mem_ready), 128'(m_age >= 0 && m_age == m_rlat));
            check("busy", 128'(bus.busy), 128'(m_age >= 0));
            if (m_rdata_known) check("rdata", bus.mem_rdata, m_rdata);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout_fail("wait_idle");
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.mem_ready !== 1'b1 && n < 60);
        if (bus.mem_ready !== 1'b1) timeout_fail("wait_ready");
    endtask

    task automatic xact(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d,
                        input int hold, output int lat, output logic [127:0] rdat);
        wait_idle();
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        wait_ready(lat);
        rdat = bus.mem_rdata;
        repeat (hold) @(negedge clk);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic count_ready(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) n++;
        end
    endtask

    int           lat, sp, n;
    logic [127:0] rd;

    initial begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        proc_reset    = 1'b1;
        repeat (3) @(negedge clk);
        proc_reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_ready", 128'(bus.mem_ready), 128'd0);
        check("rst_rdata", bus.mem_rdata, 128'd0);

        // write then read back the same line
        xact(0, 1, 28'h0000010, D1, 0, lat, rd);
        check("t1_wr_lat", 128'(lat), 128'(LAT + m_last_extra));
        xact(1, 0, 28'h0000010, '0, 0, lat, rd);
        check("t1_rd_lat", 128'(lat), 128'(LAT + m_last_extra));
        check("t1_rdata", rd, D1);

        // registered initiator keeps read high through COOL: still a single response
        xact(1, 0, 28'h0000010, '0, 2, lat, rd);
        check("t2_rdata", rd, D1);
        count_ready(12, n);
        check("t2_extra_pulses", 128'(n), 128'd0);

        // simultaneous read and write: write first, read accepted after COOL
        wait_idle();
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = 28'h0000005;
        bus.mem_wdata = 128'h1;
        wait_ready(lat);
        check("t3_wr_lat", 128'(lat), 128'(LAT + m_last_extra));
        bus.mem_write = 1'b0;
        wait_ready(sp);
        check("t3_spacing", 128'(sp), 128'(LAT + 2 + m_last_extra));
        check("t3_rdata", bus.mem_rdata, 128'h1);
        bus.mem_read = 1'b0;

        // index aliasing: upper address bits ignored
        xact(0, 1, 28'h0000103, 128'hAA, 0, lat, rd);
        xact(1, 0, 28'h0000003, '0, 0, lat, rd);
        check("t4_alias", rd, 128'hAA);

        // reset during WAIT aborts the write
        xact(0, 1, 28'h0000007, 128'h77, 0, lat, rd);
        wait_idle();
        bus.mem_write = 1'b1;
        bus.mem_addr  = 28'h0000007;
        bus.mem_wdata = 128'hFF;
        repeat (2) @(negedge clk);
        check("t5_in_wait", 128'(bus.busy), 128'd1);
        proc_reset    = 1'b1;
        bus.mem_write = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;
        check("t5_idle_after_rst", 128'(bus.busy), 128'd0);
        count_ready(10, n);
        check("t5_no_ready", 128'(n), 128'd0);
        xact(1, 0, 28'h0000007, '0, 0, lat, rd);
        check("t5_prior_data", rd, 128'h77);

        // eight reads from a fresh LFSR seed
        proc_reset = 1'b1;
        @(negedge clk);
        proc_reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xact(1, 0, 28'h0000010, '0, 0, lat, rd);
            check("t6_lat_model", 128'(lat), 128'(LAT + m_last_extra));
            check("t6_rdata", rd, D1);
`ifdef LINE_MEM_JITTER_EN
            if (i == 0) check("t6_lat0", 128'(lat), 128'd5);
            if (i == 1) check("t6_lat1", 128'(lat), 128'd6);
            if (i == 2) check("t6_lat2", 128'(lat), 128'd5);
`else
            check("t6_lat_fixed", 128'(lat), 128'd4);
`endif
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
